// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the registered-read FIFO and its read-side drain engine.
//   STAT_W       : width of the optional statistics counters
//   stat_cnt_t   : beat/stall counter pair
//   cnt_w(depth) : width of an occupancy count able to hold 0..depth
package fifo_rd_stream_pkg;

  localparam int unsigned STAT_W = 32;

  typedef struct packed {
    logic [STAT_W-1:0] beat;
    logic [STAT_W-1:0] stall;
  } stat_cnt_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of fifo_rd_stream.
//   m_valid : data valid (master -> slave)
//   m_ready : sink ready (slave -> master)
//   m_data  : payload    (master -> slave)
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_skidbuf.sv
// BUF_DEPTH-entry circular register buffer that catches words arriving from
// the FIFO's registered read port.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_push_data at the tail
//   i_pop        : drop the head entry (caller only pops when o_occ != 0)
//   o_head       : head entry
//   o_occ        : number of valid entries
module fifo_rd_skidbuf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_push,
  input  logic [DATA_WIDTH-1:0]              i_push_data,
  input  logic                               i_pop,
  output logic [DATA_WIDTH-1:0]              o_head,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     o_occ
);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned OW = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [OW-1:0]         r_occ;

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= (r_wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= (r_rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_regread.sv
// Synchronous FIFO with a registered read port: rd_data is valid in the cycle
// after an accepted read (rd_en && !empty).
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : write request / data (ignored when full)
//   rd_en, rd_data    : read request / registered read data
//   full, empty, count: status
module fifo_regread
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_wr;
  logic                  w_rd;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_rd_data;
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for fifo_regread. Issues FIFO reads, absorbs the
// one-cycle registered read latency in a small skid buffer and presents the
// words as a valid/ready stream (one beat per cycle with BUF_DEPTH=3).
//   clk, rst_n    : clock, asynchronous active-low reset
//   fifo_empty    : FIFO empty flag
//   fifo_count    : FIFO occupancy (only used by the optional stats)
//   fifo_rd_en    : FIFO read request
//   fifo_rd_data  : FIFO read data, valid the cycle after an accepted read
//   strm          : output stream (m_valid / m_ready / m_data)
// Optional build macro FIFO_RD_STREAM_STATS_EN adds beat_cnt, stall_cnt
// (saturating) and max_fill (fifo_count high-water mark).
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BUF_DEPTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [cnt_w(DEPTH)-1:0]  fifo_count,
  output logic                     fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
  fifo_rd_stream_if.master         strm
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0]        beat_cnt,
  output logic [STAT_W-1:0]        stall_cnt,
  output logic [cnt_w(DEPTH)-1:0]  max_fill
`endif
);
  localparam int unsigned OW = $clog2(BUF_DEPTH + 1);

  logic                  r_pend;
  logic [OW-1:0]         w_occ;
  logic [OW:0]           w_inflight;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_rd_en;

  // Reserve a buffer slot for every outstanding read so the word returned a
  // cycle later always has somewhere to land; only registered state and
  // fifo_empty feed this, keeping m_ready off the rd_en path.
  assign w_inflight = {1'b0, w_occ} + {{OW{1'b0}}, r_pend};
  assign w_rd_en    = !fifo_empty && (w_inflight < (OW + 1)'(BUF_DEPTH));
  assign fifo_rd_en = w_rd_en;

  assign w_valid      = (w_occ != '0);
  assign w_pop        = w_valid && strm.m_ready;
  assign strm.m_valid = w_valid;
  assign strm.m_data  = w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= 1'b0;
    else        r_pend <= w_rd_en;
  end

  fifo_rd_skidbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skidbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_pend),
    .i_push_data (fifo_rd_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  stat_cnt_t                r_stat;
  logic [cnt_w(DEPTH)-1:0]  r_max_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat     <= '0;
      r_max_fill <= '0;
    end else begin
      if (w_pop && (r_stat.beat != '1))                r_stat.beat  <= r_stat.beat + 1'b1;
      if (w_valid && !strm.m_ready && (r_stat.stall != '1)) r_stat.stall <= r_stat.stall + 1'b1;
      if (fifo_count > r_max_fill)                     r_max_fill   <= fifo_count;
    end
  end

  assign beat_cnt  = r_stat.beat;
  assign stall_cnt = r_stat.stall;
  assign max_fill  = r_max_fill;
`else
  logic w_unused_count;
  assign w_unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream attached to a real fifo_regread.
// Words written into the FIFO are queued as expected beats and retired as the
// stream hands them over. Define FIFO_RD_STREAM_STATS_EN to also cover stats.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       real_empty;
  logic [4:0] count;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       hold;       // forces the DUT to see an empty FIFO while filling
  logic       dut_empty;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;
  logic [4:0]  max_fill;
`endif

  always #5 clk = ~clk;

  assign dut_empty = real_empty | hold;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) strm ();

  fifo_regread #(.DATA_WIDTH(8), .DEPTH(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (real_empty),
    .count   (count)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .DEPTH(16), .BUF_DEPTH(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (dut_empty),
    .fifo_count   (count),
    .fifo_rd_en   (rd_en),
    .fifo_rd_data (rd_data),
    .strm         (strm)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .beat_cnt     (beat_cnt),
    .stall_cnt    (stall_cnt),
    .max_fill     (max_fill)
`endif
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         rd_seen = 0;
  int         first_rd = -1;
  int         first_vld = -1;
  int         last_beat = -1;
  int         beats = 0;
  int         stall_cycles = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge, let the posedge happen, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    chk("rd_en_while_empty", 32'(rd_en && dut_empty), 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(strm.m_valid), 32'd1);
      chk("hold_data", 32'(strm.m_data), 32'(prev_data));
    end
    if (rd_en) begin
      rd_seen++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (strm.m_valid && first_vld < 0) first_vld = cyc;
    if (strm.m_valid && !strm.m_ready) stall_cycles++;
    if (strm.m_valid && strm.m_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL beat_extra: observed=%0h expected=none", strm.m_data);
      end
      if (exp_q.size() > 0) chk("beat_data", 32'(strm.m_data), 32'(exp_q.pop_front()));
      beats++;
      last_beat = cyc;
    end
    prev_stall = strm.m_valid && !strm.m_ready;
    prev_data  = strm.m_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    prev_stall   = 1'b0;
    stall_cycles = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int r0;
    int k;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; hold = 1'b0;
    strm.m_ready = 1'b1;

    // 1: reset state, then idle with FIFO empty
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(strm.m_valid), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_data", 32'(strm.m_data), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_rd_en", 32'(rd_en), 32'd0);
      chk("idle_valid", 32'(strm.m_valid), 32'd0);
      chk("idle_data", 32'(strm.m_data), 32'd0);
      tick();
    end

    // 2: 16 words streamed with the sink always ready
    cyc = 0; first_rd = -1; first_vld = -1; b0 = beats;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    drain("s2_drain", 40);
    chk("s2_latency", 32'(first_vld - first_rd), 32'd2);
    chk("s2_beats", 32'(beats - b0), 32'd16);
    chk("s2_gapless", 32'(last_beat - first_vld), 32'd15);

    // 3: full FIFO, stalled sink
    do_reset();
    strm.m_ready = 1'b0; hold = 1'b1; b0 = beats;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    chk("s3_full_count", 32'(count), 32'd16);
    hold = 1'b0; r0 = rd_seen;
    repeat (8) tick();
    chk("s3_reads", 32'(rd_seen - r0), 32'd3);
    chk("s3_count", 32'(count), 32'd13);
    chk("s3_valid", 32'(strm.m_valid), 32'd1);
    chk("s3_data", 32'(strm.m_data), 32'h00);
    strm.m_ready = 1'b1;
    drain("s3_drain", 60);
    chk("s3_beats", 32'(beats - b0), 32'd16);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("s6_beat_cnt", beat_cnt, 32'd16);
    chk("s6_stall_cnt", stall_cnt, 32'(stall_cycles));
    chk("s6_max_fill", 32'(max_fill), 32'd16);
`endif

    // 4: random sink readiness with concurrent pushes
    b0 = beats; k = 0;
    for (int i = 0; i < 400; i++) begin
      if (k == 20 && exp_q.size() == 0) break;
      strm.m_ready = 1'($urandom_range(0, 1));
      if (k < 20 && !full) begin
        wr_en = 1'b1; wr_data = 8'(8'h80 + k); exp_q.push_back(8'(8'h80 + k)); k++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    chk("s4_left", 32'(exp_q.size()), 32'd0);
    chk("s4_beats", 32'(beats - b0), 32'd20);

    // 5: asynchronous reset with two words buffered and one read in flight
    strm.m_ready = 1'b1;
    do_reset();
    strm.m_ready = 1'b0; r0 = rd_seen;
    for (int i = 0; i < 20 && (rd_seen - r0) < 3; i++) begin
      wr_en = (i < 6); wr_data = 8'(8'h40 + i);
      if (i < 6) exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    wr_en = 1'b0;
    chk("s5_pre_reads", 32'(rd_seen - r0), 32'd3);
    chk("s5_pre_valid", 32'(strm.m_valid), 32'd1);
    chk("s5_pre_rd_en", 32'(rd_en), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_valid", 32'(strm.m_valid), 32'd0);
    chk("s5_async_rd_en", 32'(rd_en), 32'd0);
    exp_q.delete(); prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; strm.m_ready = 1'b1; b0 = beats;
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    tick();
    wr_en = 1'b1; wr_data = 8'h5B; exp_q.push_back(8'h5B);
    tick();
    wr_en = 1'b0;
    drain("s5_drain", 20);
    chk("s5_beats", 32'(beats - b0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
